// File: rtl/ddr3_burst_ctrl.sv
// Burst sequencer between a simple command/data port and a MIG user interface.
// Writes stream one beat per accept; reads issue addresses and count returns independently.
module ddr3_burst_ctrl #(
  parameter int DDR_WIDTH  = 64,
  parameter int UI_WIDTH   = DDR_WIDTH*8,
  parameter int ADDR_WIDTH = 29,
  parameter int ADDR_STEP  = 8
) (
  input  logic                    ui_clk,
  input  logic                    ui_rst,
  input  logic [2:0]              ddr_cmd,
  input  logic                    ddr_cmd_valid,
  input  logic [ADDR_WIDTH-1:0]   ddr_base_addr,
  input  logic [9:0]              ddr_size,
  input  logic [UI_WIDTH-1:0]     ddr_wdf_data,
  input  logic                    ddr_wdf_data_valid,
  output logic                    ddr_rdy,
  output logic                    ddr_wdf_data_rdy,
  output logic                    ddr_wr_finish,
  output logic [UI_WIDTH-1:0]     ddr_rd_data,
  output logic                    ddr_rd_data_valid,
  output logic                    ddr_rd_finish,
  input  logic                    init_calib_complete,
  input  logic                    app_rdy,
  input  logic                    app_wdf_rdy,
  input  logic [UI_WIDTH-1:0]     app_rd_data,
  input  logic                    app_rd_data_valid,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [UI_WIDTH-1:0]     app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [UI_WIDTH/8-1:0]   app_wdf_mask
);

  typedef enum logic [2:0] {
    S_CALIB = 3'd0,
    S_READY = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [9:0]            r_size;
  logic [9:0]            r_wr_cnt;
  logic [9:0]            r_iss_cnt;
  logic [9:0]            r_ret_cnt;
  logic                  r_rdy;
  logic                  r_wr_finish;
  logic                  r_rd_finish;
  logic                  r_rd_valid;
  logic [UI_WIDTH-1:0]   r_rd_data;

  logic                  w_in_write;
  logic                  w_in_read;
  logic                  w_wr_avail;
  logic                  w_wr_accept;
  logic                  w_rd_pending;
  logic                  w_rd_issue;
  logic                  w_ret_accept;
  logic                  w_cmd_known;
  logic [9:0]            w_addr_cnt;

  assign w_in_write   = (r_state == S_WRITE);
  assign w_in_read    = (r_state == S_READ);
  assign w_wr_avail   = w_in_write & (r_wr_cnt < r_size);
  assign w_wr_accept  = ddr_wdf_data_rdy & ddr_wdf_data_valid;
  assign w_rd_pending = w_in_read & (r_iss_cnt < r_size);
  assign w_rd_issue   = w_rd_pending & app_rdy;
  assign w_ret_accept = w_in_read & app_rd_data_valid & (r_ret_cnt < r_size);
  assign w_cmd_known  = (ddr_cmd == 3'd0) || (ddr_cmd == 3'd1);
  assign w_addr_cnt   = w_in_read ? r_iss_cnt : r_wr_cnt;

  // Command/data strobes must coincide with the accept cycle, so they stay combinational.
  assign ddr_wdf_data_rdy = app_rdy & app_wdf_rdy & w_wr_avail;
  assign app_en           = w_wr_accept | w_rd_pending;
  assign app_cmd          = w_in_read ? 3'd1 : 3'd0;
  assign app_addr         = r_base + ADDR_WIDTH'(w_addr_cnt) * ADDR_WIDTH'(ADDR_STEP);
  assign app_wdf_data     = ddr_wdf_data;
  assign app_wdf_wren     = w_wr_accept;
  assign app_wdf_end      = w_wr_accept;
  assign app_wdf_mask     = {(UI_WIDTH/8){1'b0}};

  assign ddr_rdy           = r_rdy;
  assign ddr_wr_finish     = r_wr_finish;
  assign ddr_rd_finish     = r_rd_finish;
  assign ddr_rd_data_valid = r_rd_valid;
  assign ddr_rd_data       = r_rd_data;

  // Burst state machine with its counters and registered status outputs.
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      r_state     <= S_CALIB;
      r_base      <= {ADDR_WIDTH{1'b0}};
      r_size      <= 10'd0;
      r_wr_cnt    <= 10'd0;
      r_iss_cnt   <= 10'd0;
      r_ret_cnt   <= 10'd0;
      r_rdy       <= 1'b0;
      r_wr_finish <= 1'b0;
      r_rd_finish <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= {UI_WIDTH{1'b0}};
    end else begin
      r_wr_finish <= 1'b0;
      r_rd_finish <= 1'b0;
      r_rd_valid  <= 1'b0;
      // Losing calibration aborts whatever is in flight without reporting completion.
      if (!init_calib_complete) begin
        r_state   <= S_CALIB;
        r_rdy     <= 1'b0;
        r_wr_cnt  <= 10'd0;
        r_iss_cnt <= 10'd0;
        r_ret_cnt <= 10'd0;
      end else begin
        case (r_state)
          S_CALIB: begin
            r_state <= S_READY;
            r_rdy   <= 1'b1;
          end
          S_READY: begin
            if (ddr_cmd_valid && w_cmd_known) begin
              r_base    <= ddr_base_addr;
              r_size    <= ddr_size;
              r_wr_cnt  <= 10'd0;
              r_iss_cnt <= 10'd0;
              r_ret_cnt <= 10'd0;
              r_rdy     <= 1'b0;
              if (ddr_size == 10'd0) begin
                r_state     <= S_DONE;
                r_wr_finish <= (ddr_cmd == 3'd0);
                r_rd_finish <= (ddr_cmd == 3'd1);
              end else if (ddr_cmd == 3'd0) begin
                r_state <= S_WRITE;
              end else begin
                r_state <= S_READ;
              end
            end
          end
          S_WRITE: begin
            if (w_wr_accept) begin
              r_wr_cnt <= r_wr_cnt + 10'd1;
              if (r_wr_cnt + 10'd1 == r_size) begin
                r_state     <= S_DONE;
                r_wr_finish <= 1'b1;
              end
            end
          end
          S_READ: begin
            if (w_rd_issue) begin
              r_iss_cnt <= r_iss_cnt + 10'd1;
            end
            // Returns are counted independently of issues so overlapping cycles lose nothing.
            if (w_ret_accept) begin
              r_ret_cnt  <= r_ret_cnt + 10'd1;
              r_rd_valid <= 1'b1;
              r_rd_data  <= app_rd_data;
              if (r_ret_cnt + 10'd1 == r_size) begin
                r_state     <= S_DONE;
                r_rd_finish <= 1'b1;
              end
            end
          end
          S_DONE: begin
            r_state <= S_READY;
            r_rdy   <= 1'b1;
          end
          default: begin
            r_state <= S_CALIB;
            r_rdy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_burst_ctrl.sv
// Directed bench for ddr3_burst_ctrl: a negedge monitor pops scoreboard queues filled by stimulus.
module tb_ddr3_burst_ctrl;
  localparam int AW = 29;
  localparam int UW = 512;
  localparam int MW = UW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    ddr_cmd;
  logic          ddr_cmd_valid;
  logic [AW-1:0] ddr_base_addr;
  logic [9:0]    ddr_size;
  logic [UW-1:0] ddr_wdf_data;
  logic          ddr_wdf_data_valid;
  logic          ddr_rdy, ddr_wdf_data_rdy, ddr_wr_finish;
  logic [UW-1:0] ddr_rd_data;
  logic          ddr_rd_data_valid, ddr_rd_finish;
  logic          init_calib_complete, app_rdy, app_wdf_rdy;
  logic [UW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic [UW-1:0] app_wdf_data;
  logic          app_wdf_wren, app_wdf_end;
  logic [MW-1:0] app_wdf_mask;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int wr_beats = 0, rd_issues = 0, rd_valids = 0, wr_fin_cnt = 0, rd_fin_cnt = 0;
  int rd_target = 0, ret_delay = 10;
  logic [AW-1:0] exp_wr_addr[$], exp_rd_addr[$];
  logic [UW-1:0] exp_wr_data[$], exp_rd_data[$], ret_data[$], plan[$];
  int ret_due[$], exp_rd_cyc[$];

  ddr3_burst_ctrl dut (
    .ui_clk(clk), .ui_rst(rst),
    .ddr_cmd(ddr_cmd), .ddr_cmd_valid(ddr_cmd_valid), .ddr_base_addr(ddr_base_addr),
    .ddr_size(ddr_size), .ddr_wdf_data(ddr_wdf_data), .ddr_wdf_data_valid(ddr_wdf_data_valid),
    .ddr_rdy(ddr_rdy), .ddr_wdf_data_rdy(ddr_wdf_data_rdy), .ddr_wr_finish(ddr_wr_finish),
    .ddr_rd_data(ddr_rd_data), .ddr_rd_data_valid(ddr_rd_data_valid), .ddr_rd_finish(ddr_rd_finish),
    .init_calib_complete(init_calib_complete), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [UW-1:0] rand_word();
    logic [UW-1:0] w;
    for (int i = 0; i < UW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: each read issue is answered ret_delay cycles later, in order.
  initial begin : return_driver
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = ret_data.pop_front();
        void'(ret_due.pop_front());
        exp_rd_data.push_back(app_rd_data);
        exp_rd_cyc.push_back(cyc + 1);
      end else begin
        app_rd_data_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic [UW-1:0] d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (app_wdf_wren) begin
          wr_beats++;
          check("wr_app_en", app_en, 1'b1);
          check("wr_wdf_end", app_wdf_end, 1'b1);
          check("wr_app_cmd", app_cmd, 3'd0);
          check("wr_wdf_rdy_high", app_wdf_rdy, 1'b1);
          check("wr_mask", app_wdf_mask, '0);
          check("wr_expected", exp_wr_addr.size() > 0, 1'b1);
          if (exp_wr_addr.size() > 0) begin
            check("wr_addr", app_addr, exp_wr_addr.pop_front());
            check("wr_data", app_wdf_data, exp_wr_data.pop_front());
          end
        end else if (app_en && app_rdy) begin
          rd_issues++;
          check("rd_app_cmd", app_cmd, 3'd1);
          check("rd_expected", exp_rd_addr.size() > 0, 1'b1);
          if (exp_rd_addr.size() > 0) check("rd_addr", app_addr, exp_rd_addr.pop_front());
          d = rand_word();
          ret_data.push_back(d);
          ret_due.push_back(cyc + ret_delay);
        end
        if (ddr_rd_data_valid) begin
          rd_valids++;
          check("rd_valid_expected", exp_rd_data.size() > 0, 1'b1);
          if (exp_rd_data.size() > 0) begin
            check("rd_data", ddr_rd_data, exp_rd_data.pop_front());
            check("rd_latency", cyc, exp_rd_cyc.pop_front());
          end
          check("rd_finish_align", ddr_rd_finish, rd_valids == rd_target);
        end
        if (ddr_wr_finish) wr_fin_cnt++;
        if (ddr_rd_finish) rd_fin_cnt++;
      end
    end
  end

  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] b, input int s);
    ddr_cmd = c;
    ddr_base_addr = b;
    ddr_size = 10'(s);
    ddr_cmd_valid = 1'b1;
    tick();
    ddr_cmd_valid = 1'b0;
  endtask

  // Streams up to n_stop beats of a planned write burst; returns the number accepted.
  task automatic drive_write(input logic [AW-1:0] b, input int s, input int n_stop,
                             input bit toggle, output int k);
    int g = 0;
    k = 0;
    plan.delete();
    for (int i = 0; i < s; i++) begin
      logic [UW-1:0] w;
      w = rand_word();
      plan.push_back(w);
      exp_wr_data.push_back(w);
      exp_wr_addr.push_back(AW'(b + i*8));
    end
    send_cmd(3'd0, b, s);
    ddr_wdf_data_valid = 1'b1;
    while (k < n_stop && g < 100) begin
      ddr_wdf_data = plan[k];
      app_wdf_rdy = toggle ? (g % 2 == 0) : 1'b1;
      @(negedge clk);
      if (ddr_wdf_data_rdy) k++;
      tick();
      g++;
    end
  endtask

  task automatic run_write(input string tag, input logic [AW-1:0] b, input int s, input bit toggle);
    int k;
    int beats0 = wr_beats;
    int fin0 = wr_fin_cnt;
    drive_write(b, s, s, toggle, k);
    ddr_wdf_data_valid = 1'b0;
    app_wdf_rdy = 1'b1;
    check({tag, "_beats_done"}, k, s);
    check({tag, "_finish"}, ddr_wr_finish, 1'b1);
    check({tag, "_beats_issued"}, wr_beats - beats0, s);
    tick();
    check({tag, "_finish_clear"}, ddr_wr_finish, 1'b0);
    check({tag, "_rdy_back"}, ddr_rdy, 1'b1);
    check({tag, "_finish_count"}, wr_fin_cnt - fin0, 1);
  endtask

  task automatic run_read(input string tag, input logic [AW-1:0] b, input int s,
                          input bit stall, input int delay);
    int c = 0;
    bit done = 1'b0;
    int iss0 = rd_issues;
    int fin0 = rd_fin_cnt;
    ret_delay = delay;
    for (int i = 0; i < s; i++) exp_rd_addr.push_back(AW'(b + i*8));
    rd_target = rd_valids + s;
    send_cmd(3'd1, b, s);
    while (!done && c < 100) begin
      app_rdy = (stall && (c == 2 || c == 3)) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (ddr_rd_finish) done = 1'b1;
      tick();
      c++;
    end
    app_rdy = 1'b1;
    check({tag, "_finished"}, done, 1'b1);
    check({tag, "_rdy_back"}, ddr_rdy, 1'b1);
    check({tag, "_issues"}, rd_issues - iss0, s);
    check({tag, "_valids"}, rd_valids, rd_target);
    check({tag, "_finish_count"}, rd_fin_cnt - fin0, 1);
    check({tag, "_addr_left"}, exp_rd_addr.size(), 0);
  endtask

  initial begin : stimulus
    int k;
    int fin0;
    int beats0;
    rst = 1'b1;
    init_calib_complete = 1'b0;
    ddr_cmd = 3'd0;
    ddr_cmd_valid = 1'b0;
    ddr_base_addr = '0;
    ddr_size = 10'd0;
    ddr_wdf_data = '0;
    ddr_wdf_data_valid = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (3) tick();
    check("rst_rdy", ddr_rdy, 1'b0);
    check("rst_wr_finish", ddr_wr_finish, 1'b0);
    check("rst_rd_finish", ddr_rd_finish, 1'b0);
    check("rst_rd_valid", ddr_rd_data_valid, 1'b0);
    check("rst_rd_data", ddr_rd_data, '0);
    check("rst_app_en", app_en, 1'b0);
    check("rst_mask", app_wdf_mask, '0);
    rst = 1'b0;
    tick();
    check("calib_wait_rdy", ddr_rdy, 1'b0);
    init_calib_complete = 1'b1;
    tick();
    check("calib_done_rdy", ddr_rdy, 1'b1);

    ddr_wdf_data_valid = 1'b1;
    #1;
    check("ready_wdf_rdy", ddr_wdf_data_rdy, 1'b0);
    check("ready_app_en", app_en, 1'b0);
    ddr_wdf_data_valid = 1'b0;
    send_cmd(3'd5, 29'h0, 4);
    check("bad_cmd_rdy", ddr_rdy, 1'b1);
    check("bad_cmd_app_en", app_en, 1'b0);

    run_write("wr4", 29'h100, 4, 1'b0);
    run_write("wr3_toggle", 29'h300, 3, 1'b1);
    run_read("rd5_stall", 29'h40, 5, 1'b1, 10);
    run_read("rd4_overlap", 29'h800, 4, 1'b0, 1);
    run_write("wr0", 29'h500, 0, 1'b0);
    run_read("rd0", 29'h600, 0, 1'b0, 10);
    run_write("wrap", 29'h1FFFFFF8, 2, 1'b0);

    init_calib_complete = 1'b0;
    tick();
    check("calib_drop_rdy", ddr_rdy, 1'b0);
    init_calib_complete = 1'b1;
    tick();
    check("calib_regain_rdy", ddr_rdy, 1'b1);

    beats0 = wr_beats;
    fin0 = wr_fin_cnt;
    drive_write(29'h200, 4, 2, 1'b0, k);
    check("abort_two_beats", k, 2);
    rst = 1'b1;
    #1;
    check("abort_app_en", app_en, 1'b0);
    check("abort_wren", app_wdf_wren, 1'b0);
    check("abort_wdf_rdy", ddr_wdf_data_rdy, 1'b0);
    check("abort_rdy", ddr_rdy, 1'b0);
    check("abort_wr_finish", ddr_wr_finish, 1'b0);
    ddr_wdf_data_valid = 1'b0;
    exp_wr_addr.delete();
    exp_wr_data.delete();
    tick();
    tick();
    rst = 1'b0;
    check("abort_calib_rdy", ddr_rdy, 1'b0);
    tick();
    check("abort_ready_again", ddr_rdy, 1'b1);
    check("abort_no_finish", wr_fin_cnt - fin0, 0);
    check("abort_beats", wr_beats - beats0, 2);

    run_write("post_abort", 29'h1000, 2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_burst_ctrl.md
DDR3_BURST_CTRL -- requirements
Module: ddr3_burst_ctrl

Interface
REQ-001 SHALL have parameter DDR_WIDTH, default 64, DDR data width in bits.
REQ-002 SHALL have parameter UI_WIDTH, default DDR_WIDTH*8, app data width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 29, app address width in bits.
REQ-004 SHALL have parameter ADDR_STEP, default 8, app_addr increment per beat.
REQ-005 ui_clk  in  1  sole clock; everything is synchronous to its rising edge.
REQ-006 ui_rst  in  1  reset, asynchronous, active-high.
REQ-007 ddr_cmd  in  3  0=write, 1=read; any other value is ignored.
REQ-008 ddr_cmd_valid  in  1  command strobe.
REQ-009 ddr_base_addr  in  ADDR_WIDTH  first beat address.
REQ-010 ddr_size  in  10  beat count, 0..1023.
REQ-011 ddr_wdf_data  in  UI_WIDTH  write beat.
REQ-012 ddr_wdf_data_valid  in  1  write beat valid.
REQ-013 ddr_rdy  out  1  ready to accept a command.
REQ-014 ddr_wdf_data_rdy  out  1  write beat can be taken.
REQ-015 ddr_wr_finish  out  1  one-cycle pulse marking write burst complete.
REQ-016 ddr_rd_data  out  UI_WIDTH  read beat.
REQ-017 ddr_rd_data_valid  out  1  read beat valid.
REQ-018 ddr_rd_finish  out  1  one-cycle pulse marking read burst complete.
REQ-019 init_calib_complete, app_rdy, app_wdf_rdy  in  1 each  MIG status.
REQ-020 app_rd_data  in  UI_WIDTH; app_rd_data_valid  in  1  MIG read return.
REQ-021 app_en  out  1; app_cmd  out  3; app_addr  out  ADDR_WIDTH  MIG command port.
REQ-022 app_wdf_data  out  UI_WIDTH; app_wdf_wren, app_wdf_end  out  1; app_wdf_mask  out  UI_WIDTH/8  MIG write data port.

Function
REQ-023 States SHALL be CALIB, READY, WRITE, READ, DONE.
REQ-024 CALIB->READY when init_calib_complete=1.
REQ-025 ddr_rdy SHALL be 1 only in READY.
REQ-026 In READY with ddr_cmd_valid=1, SHALL latch ddr_base_addr and ddr_size, clear all counters, and go to WRITE (cmd 0) or READ (cmd 1); other cmd values leave the state in READY.
REQ-027 A latched size of 0 SHALL go directly to DONE and pulse the matching finish flag.
REQ-028 WRITE: ddr_wdf_data_rdy = app_rdy & app_wdf_rdy & (wr_cnt<size), combinational.
REQ-029 WRITE: beat accepted when ddr_wdf_data_rdy & ddr_wdf_data_valid; in the same cycle app_en=app_wdf_wren=app_wdf_end=1, app_cmd=0, app_wdf_data=ddr_wdf_data.
REQ-030 Each accepted beat SHALL increment wr_cnt.
REQ-031 app_addr = base + cnt*ADDR_STEP, truncated modulo 2^ADDR_WIDTH (wraps).
REQ-032 ddr_wdf_data_valid SHALL be ignored outside accept cycles; no beat is issued beyond size.
REQ-033 After the last write beat is accepted, the next state is DONE and ddr_wr_finish pulses 1 cycle, registered (1 cycle after the last accept).
REQ-034 READ: app_en=1, app_cmd=1 while iss_cnt<size; iss_cnt increments on app_en&app_rdy.
REQ-035 READ: ddr_rd_data/ddr_rd_data_valid SHALL register app_rd_data/app_rd_data_valid (1-cycle latency); ret_cnt counts returns.
REQ-036 READ: when ret_cnt reaches size, the next state is DONE and ddr_rd_finish pulses aligned with the last ddr_rd_data_valid.
REQ-037 Returns arriving in the same cycles as issues SHALL be counted with no loss.
REQ-038 DONE->READY after 1 cycle.
REQ-039 app_wdf_mask SHALL be constant 0.
REQ-040 app_en, app_wdf_wren, and app_wdf_end SHALL be 0 in CALIB, READY, and DONE.
REQ-041 init_calib_complete dropping in any state SHALL return the block to CALIB; counters clear and no finish pulse is produced.

Reset
REQ-042 ui_rst=1 SHALL force state CALIB, clear counters, and clear all registered outputs: ddr_rdy, finish pulses, and rd valid are 0; ddr_rd_data is 0.
REQ-043 Reset asserted mid-burst SHALL abort the burst without any finish pulse; after release the block waits for calibration again.

Verification
REQ-044 Calib raised, cmd write, base 0x100, size 4, app_rdy/app_wdf_rdy tied 1, valid held 1 -> app_addr 0x100,0x108,0x110,0x118; 4 wren; ddr_wr_finish 1 cycle after 4th beat; ddr_rdy returns.
REQ-045 Write size 3 with app_wdf_rdy toggling 1/0 -> exactly 3 beats issued, none while app_wdf_rdy=0, data order preserved.
REQ-046 Read base 0x40, size 5, app_rdy low 2 cycles mid-issue, returns delayed 10 cycles -> 5 issues at 0x40..0x60; 5 rd valids 1 cycle after app returns; rd_finish on the 5th.
REQ-047 Size 0 write -> no app_en; ddr_wr_finish pulses; back to READY.
REQ-048 Base 0x1FFFFFF8 size 2 -> second app_addr 0x00000000 (wrap).
REQ-049 ui_rst pulsed after 2 of 4 write beats -> outputs cleared immediately, no finish pulse, CALIB then READY after calib.
